// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM multiplier arbiter slice.
//   IDDMM_WIDTH       : operand width; the product is twice as wide
//   IDDMM_MUL_LATENCY : operand-register update to valid multiplier product
//   IDDMM_ID_W        : tag ID width, wide enough for up to 8 requesters
//   arb_state_t       : arbiter sequencing states
//   tag_t             : in-flight tag carried alongside the multiplier pipe
package iddmm_pkg;

   localparam int unsigned IDDMM_WIDTH       = 256;
   localparam int unsigned IDDMM_MUL_LATENCY = 8;
   localparam int unsigned IDDMM_ID_W        = 3;

   typedef enum logic [1:0] {
      ARB_RUN,
      ARB_DRAIN,
      ARB_HALT
   } arb_state_t;

   typedef struct packed {
      logic                  vld;
      logic [IDDMM_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/iddmm_mul_256_to_512.sv
// Fixed-latency WIDTH x WIDTH -> 2*WIDTH multiplier.
// The product of x/y becomes visible on result LATENCY edges after x/y change.
//   clk, rst_n : clock, synchronous active-low reset
//   x, y       : operands (driven from registers in the parent)
//   result     : product, LATENCY cycles later
module iddmm_mul_256_to_512
   import iddmm_pkg::*;
#(
   parameter int unsigned WIDTH   = IDDMM_WIDTH,
   parameter int unsigned LATENCY = IDDMM_MUL_LATENCY
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic [2*WIDTH-1:0]   result
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [PW-1:0] prod_q [LATENCY];

   // Multiply in the first stage, then delay to the configured depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         prod_q[0] <= PW'(x) * PW'(y);
         for (int i = 1; i < int'(LATENCY); i++) begin
            prod_q[i] <= prod_q[i-1];
         end
      end
   end

   assign result = prod_q[LATENCY-1];

endmodule

// File: rtl/iddmm_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier among NUM_REQ
// requesters; a tag pipe steers each product back to its issuer.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is the one-hot grant)
//   req_x, req_y        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid, rsp_id   : one-hot response pulse and its requester ID
//   rsp_data            : shared product bus, qualified by rsp_valid
//   pause, idle         : drain/halt control and quiescence indication
// Optional: define IDDMM_ARB_STATS_EN to add stat_issue / stat_stall counters.
module iddmm_mul_arbiter
   import iddmm_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_W        = $clog2(NUM_REQ),
   parameter int unsigned MUL_LATENCY = IDDMM_MUL_LATENCY,
   parameter int unsigned WIDTH       = IDDMM_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_x,
   input  logic [NUM_REQ*WIDTH-1:0]   req_y,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [2*WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]            rsp_id,
   input  logic                       pause,
   output logic                       idle
`ifdef IDDMM_ARB_STATS_EN
   ,
   output logic [31:0]                stat_issue,
   output logic [31:0]                stat_stall
`endif
);

   arb_state_t                      state_q, state_d;
   logic [ID_W-1:0]                 last_grant_q;
   logic [WIDTH-1:0]                x_q, y_q;
   tag_t                            tag_q [MUL_LATENCY];
   tag_t                            out_tag;
   logic [NUM_REQ-1:0]              rsp_valid_q;
   logic [ID_W-1:0]                 rsp_id_q;

   logic [NUM_REQ-1:0][WIDTH-1:0]   req_x_a, req_y_a;
   logic                            win_vld_c;
   logic [ID_W-1:0]                 win_id_c;
   logic                            xfer_c;
   logic                            pipe_busy_c;

   assign req_x_a = req_x;
   assign req_y_a = req_y;

   // Round-robin pick: search from last_grant+1, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      win_vld_c = 1'b0;
      win_id_c  = '0;
      idx       = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + k) % NUM_REQ;
         if (!win_vld_c && req_valid[ID_W'(idx)]) begin
            win_vld_c = 1'b1;
            win_id_c  = ID_W'(idx);
         end
      end
   end

   // Grants only in RUN and never while reset is asserted.
   assign xfer_c = rst_n && (state_q == ARB_RUN) && win_vld_c;

   always_comb begin
      req_ready = '0;
      if (xfer_c) begin
         req_ready[win_id_c] = 1'b1;
      end
   end

   always_comb begin
      pipe_busy_c = 1'b0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
         pipe_busy_c = pipe_busy_c | tag_q[i].vld;
      end
   end

   assign idle = !rst_n || (!pipe_busy_c && !xfer_c);

   // DRAIN holds off new grants until every in-flight tag has left the pipe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_RUN:   if (pause) state_d = ARB_DRAIN;
         ARB_DRAIN: begin
            if (!pause) begin
               state_d = ARB_RUN;
            end else if (!pipe_busy_c) begin
               state_d = ARB_HALT;
            end
         end
         ARB_HALT:  if (!pause) state_d = ARB_RUN;
         default:   state_d = ARB_RUN;
      endcase
   end

   assign out_tag = tag_q[MUL_LATENCY-1];

   // State, operand registers, tag pipe and registered response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ARB_RUN;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         x_q          <= '0;
         y_q          <= '0;
         for (int i = 0; i < int'(MUL_LATENCY); i++) begin
            tag_q[i] <= '0;
         end
         rsp_valid_q  <= '0;
         rsp_id_q     <= '0;
      end else begin
         state_q <= state_d;
         if (xfer_c) begin
            last_grant_q <= win_id_c;
            x_q          <= req_x_a[win_id_c];
            y_q          <= req_y_a[win_id_c];
         end
         tag_q[0].vld <= xfer_c;
         tag_q[0].id  <= xfer_c ? IDDMM_ID_W'(win_id_c) : IDDMM_ID_W'(0);
         for (int i = 1; i < int'(MUL_LATENCY); i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         // The registered output stage lines up with the multiplier result.
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_valid_q[i] <= out_tag.vld && (out_tag.id == IDDMM_ID_W'(i));
         end
         rsp_id_q <= ID_W'(out_tag.id);
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;

   iddmm_mul_256_to_512 #(
      .WIDTH   (WIDTH),
      .LATENCY (MUL_LATENCY)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .x      (x_q),
      .y      (y_q),
      .result (rsp_data)
   );

`ifdef IDDMM_ARB_STATS_EN
   logic [31:0] stat_issue_q, stat_stall_q;

   // Saturating issue / stall counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_issue_q <= '0;
         stat_stall_q <= '0;
      end else begin
         if (xfer_c && (stat_issue_q != 32'hFFFF_FFFF)) begin
            stat_issue_q <= stat_issue_q + 32'd1;
         end
         if ((|req_valid) && !xfer_c && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign stat_issue = stat_issue_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_iddmm_mul_arbiter.sv
// Self-checking bench for iddmm_mul_arbiter: a queue-based reference model
// checks every cycle, directed scenarios pin literal expectations.
`timescale 1ns/1ps
module tb_iddmm_mul_arbiter;

   localparam int NR = 4;
   localparam int W  = 256;
   localparam int L  = 8;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*W-1:0]   req_x, req_y;
   logic [NR-1:0]     rsp_valid;
   logic [2*W-1:0]    rsp_data;
   logic [1:0]        rsp_id;
   logic              pause;
   logic              idle;
`ifdef IDDMM_ARB_STATS_EN
   logic [31:0]       stat_issue, stat_stall;
`endif

   iddmm_mul_arbiter #(.NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .pause     (pause),
      .idle      (idle)
`ifdef IDDMM_ARB_STATS_EN
      ,
      .stat_issue(stat_issue),
      .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- requester driver ----------------
   logic [NR-1:0]          rv;
   logic [W-1:0]           rx [NR];
   logic [W-1:0]           ry [NR];
   int                     left [NR];
   logic [NR-1:0][W-1:0]   px, py;

   logic [NR-1:0]  g_s, rs_v, rs_or;
   logic [511:0]   rs_d;
   logic [1:0]     rs_id;
   int             g_edge, rs_edge, rsp_cnt;
   int             gseq[$];

   function automatic logic [W-1:0] r256();
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < W / 32; k++) v = {v[W-33:0], 32'($urandom())};
      return v;
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         px[i] = rx[i];
         py[i] = ry[i];
      end
      req_x     = px;
      req_y     = py;
      req_valid = rv;
   endtask

   // One clock: sample at the falling edge, update requesters after the rising edge.
   task automatic cycle();
      @(negedge clk);
      g_s     = req_ready & req_valid;
      rs_v    = rsp_valid;
      rs_d    = rsp_data;
      rs_id   = rsp_id;
      rs_edge = ecnt;
      rs_or   = rs_or | rsp_valid;
      if (rsp_valid != '0) rsp_cnt++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (g_s[i]) begin
            gseq.push_back(i);
            g_edge = ecnt;
            left[i]--;
            if (left[i] > 0) begin
               rx[i] = r256();
               ry[i] = r256();
            end else begin
               rv[i] = 1'b0;
            end
         end
      end
      drive();
   endtask

   task automatic set_all(input logic [NR-1:0] mask, input int n);
      for (int i = 0; i < NR; i++) begin
         if (mask[i]) begin
            rv[i]   = 1'b1;
            left[i] = n;
            rx[i]   = r256();
            ry[i]   = r256();
         end
      end
      drive();
   endtask

   task automatic do_reset();
      rv    = '0;
      rst_n = 1'b0;
      drive();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic single(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [511:0] exp, input string nm);
      bit got, seen;
      int e0;
      rv       = '0;
      rv[id]   = 1'b1;
      rx[id]   = x;
      ry[id]   = y;
      left[id] = 1;
      drive();
      got = 0;
      e0  = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         cycle();
         if (g_s[id]) got = 1;
      end
      chk({nm, " grant"}, 512'(got), 512'(1));
      e0   = g_edge;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         cycle();
         if (rs_v != '0) seen = 1;
      end
      chk({nm, " rsp seen"}, 512'(seen), 512'(1));
      chk({nm, " latency"}, 512'(rs_edge - e0), 512'(L));
      chk({nm, " rsp_valid"}, 512'(rs_v), 512'(4'b0001 << id));
      chk({nm, " rsp_id"}, 512'(rs_id), 512'(id));
      chk({nm, " rsp_data"}, rs_d, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int           eidx;
      int           id;
      logic [W-1:0] x;
      logic [W-1:0] y;
   } iss_t;

   iss_t mq[$];
   int   m_c = 0;
   int   m_last = NR - 1;
   int   m_st = M_RUN;
   bit   m_rst_prev = 1'b1;

   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (last + k) % NR;
         if (v[2'(idx)]) return idx;
      end
      return -1;
   endfunction

   initial begin : model
      iss_t          ent, nw;
      bit            has, empty, xfer;
      int            win;
      logic [NR-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         m_c++;
         has = 0;
         if (mq.size() > 0 && mq[0].eidx == m_c - L) begin
            ent = mq.pop_front();
            has = 1;
         end
         if (has) begin
            chk("model rsp_valid", 512'(rsp_valid), 512'(4'b0001 << ent.id));
            chk("model rsp_id", 512'(rsp_id), 512'(ent.id));
            chk("model rsp_data", rsp_data, 512'(ent.x) * 512'(ent.y));
         end else begin
            chk("model rsp_valid idle", 512'(rsp_valid), 512'(0));
         end
         if (m_rst_prev) chk("model rsp_id after reset", 512'(rsp_id), 512'(0));
         empty   = (mq.size() == 0);
         win     = rr_pick(req_valid, m_last);
         xfer    = rst_n && (m_st == M_RUN) && (win >= 0);
         exp_rdy = xfer ? (4'b0001 << win) : 4'b0000;
         chk("model req_ready", 512'(req_ready), 512'(exp_rdy));
         chk("model idle", 512'(idle), 512'(!rst_n || (empty && !xfer)));
         m_rst_prev = !rst_n;
         if (!rst_n) begin
            mq.delete();
            m_last = NR - 1;
            m_st   = M_RUN;
         end else begin
            if (xfer) begin
               nw.eidx = m_c + 1;
               nw.id   = win;
               nw.x    = px[2'(win)];
               nw.y    = py[2'(win)];
               mq.push_back(nw);
               m_last = win;
            end
            case (m_st)
               M_RUN:   if (pause) m_st = M_DRAIN;
               M_DRAIN: if (!pause) m_st = M_RUN; else if (empty) m_st = M_HALT;
               default: if (!pause) m_st = M_RUN;
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [W-1:0]   ones;
      logic [511:0]   exp_max;
      int             bad, n;
      rst_n = 1'b0;
      pause = 1'b0;
      rv    = '0;
      rs_or = '0;
      rsp_cnt = 0;
      g_edge  = 0;
      for (int i = 0; i < NR; i++) begin
         rx[i] = '0;
         ry[i] = '0;
         left[i] = 0;
      end
      drive();
      cycle();
      cycle();
      rst_n = 1'b1;
      chk("reset idle", 512'(idle), 512'(1));
      chk("reset ready", 512'(req_ready), 512'(0));

      single(0, 256'd3, 256'd5, 512'd15, "3x5");

      // All four valid: strict rotation, one issue per cycle.
      do_reset();
      gseq.delete();
      set_all(4'b1111, 25);
      n = 0;
      for (int t = 0; t < 300 && rv != '0; t++) begin
         cycle();
         n++;
      end
      chk("rotate cycles", 512'(n), 512'(100));
      bad = 0;
      for (int k = 0; k < gseq.size(); k++) if (gseq[k] != k % 4) bad++;
      chk("rotate count", 512'(gseq.size()), 512'(100));
      chk("rotate order", 512'(bad), 512'(0));
      repeat (L + 2) cycle();

      // Only requesters 1 and 3.
      do_reset();
      gseq.delete();
      rs_or = '0;
      set_all(4'b1010, 6);
      for (int t = 0; t < 100 && rv != '0; t++) cycle();
      repeat (L + 2) cycle();
      bad = 0;
      for (int k = 0; k < gseq.size(); k++) if (gseq[k] != ((k % 2 == 0) ? 1 : 3)) bad++;
      chk("alt count", 512'(gseq.size()), 512'(12));
      chk("alt order", 512'(bad), 512'(0));
      chk("alt no rsp to 0/2", 512'(rs_or & 4'b0101), 512'(0));

      ones    = '1;
      exp_max = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
      single(2, ones, ones, exp_max, "max");
      single(1, 256'd0, r256(), 512'd0, "zero");

      // Pause with three operations in flight.
      do_reset();
      rsp_cnt = 0;
      set_all(4'b1111, 50);
      cycle();
      cycle();
      pause = 1'b1;
      drive();
      cycle();
      chk("pause last grant", 512'(g_s), 512'(4'b0100));
      cycle();
      chk("pause ready off", 512'(g_s), 512'(0));
      repeat (L + 3) cycle();
      chk("drain rsp count", 512'(rsp_cnt), 512'(3));
      chk("halt idle", 512'(idle), 512'(1));
      chk("halt ready", 512'(req_ready), 512'(0));
      pause = 1'b0;
      drive();
      cycle();
      cycle();
      chk("resume grant", 512'(g_s), 512'(4'b1000));

      // Reset with five operations in flight.
      repeat (4) cycle();
      do_reset();
      rsp_cnt = 0;
      repeat (L + 3) cycle();
      chk("post reset rsp", 512'(rsp_cnt), 512'(0));
      chk("post reset idle", 512'(idle), 512'(1));
`ifdef IDDMM_ARB_STATS_EN
      chk("post reset stat_issue", 512'(stat_issue), 512'(0));
`endif
      set_all(4'b1111, 1);
      cycle();
      chk("post reset first grant", 512'(g_s), 512'(4'b0001));

      // Random traffic with pause toggling.
      for (int t = 0; t < 800; t++) begin
         for (int i = 0; i < NR; i++) begin
            if (!rv[i] && $urandom_range(0, 3) == 0) begin
               rv[i]   = 1'b1;
               left[i] = $urandom_range(1, 4);
               rx[i]   = r256();
               ry[i]   = r256();
            end
         end
         if ($urandom_range(0, 15) == 0) pause = ~pause;
         drive();
         cycle();
      end
      pause = 1'b0;
      drive();
      for (int t = 0; t < 400 && rv != '0; t++) cycle();
      chk("random drained", 512'(rv), 512'(0));
      repeat (L + 3) cycle();
      chk("final idle", 512'(idle), 512'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/iddmm_mul_arbiter.md
Name: iddmm_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fixed-latency iddmm_mul_256_to_512 multiplier among NUM_REQ requesters.
- Accepts one 256x256 multiply per cycle from the winning requester and registers the operands into the multiplier.
- Tracks the in-flight requester ID through a tag pipeline matched to the multiplier depth, so each 512-bit product is steered back to the requester that issued it.
- Provides a pause/drain control for the Paillier top-level sequencer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), requester ID width
MUL_LATENCY, 8, cycles from operand-register update to valid product at multiplier output
WIDTH, 256, operand width; product is 2*WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low, sampled on rising edge of clk
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_x  in  NUM_REQ*WIDTH  packed operand x, requester i at [i*WIDTH +: WIDTH]
req_y  in  NUM_REQ*WIDTH  packed operand y, same packing
rsp_valid  out  NUM_REQ  one-hot pulse, product for requester i
rsp_data  out  2*WIDTH  product x*y, shared by all requesters
rsp_id  out  ID_W  ID of current response
pause  in  1  stop issuing new requests
idle  out  1  no request in flight and no grant this cycle

Behaviour:
- Reset (rst_n=0 at an edge):
  - Operand registers, tag valid pipe and tag IDs clear to 0.
  - RR pointer set so requester 0 has highest priority.
  - FSM goes to RUN.
  - Outputs: rsp_valid=0, rsp_id=0, req_ready=0 during reset, idle=1.
  - All in-flight operations are discarded; no rsp_valid for them after reset releases. rsp_data may carry multiplier garbage but is qualified only by rsp_valid.
- Arbitration:
  - Combinational round-robin over req_valid, starting at last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready[i]=1 only for the winner, and only in RUN.
  - A transfer occurs when req_valid[i]&&req_ready[i] at a rising edge.
  - last_grant updates only on a transfer. With no transfer, the pointer holds.
  - Requesters hold valid and operands stable until ready. Dropping valid before ready is a protocol error and is not checked.
- Issue:
  - On a transfer at edge E0, the operand registers load req_x/req_y of the winner.
  - Tag pipe stage 0 loads {1, winner ID}.
  - With no transfer, stage 0 loads valid=0 and the operand registers hold.
- Tag pipe:
  - MUL_LATENCY-stage shift register, shifting every cycle, with no stall.
  - Output stage aligns with the product: rsp_valid goes high in the cycle after edge E0+MUL_LATENCY. Total latency from accepting edge to rsp_valid is MUL_LATENCY cycles after the operand load.
  - rsp_data is the multiplier output directly.
  - rsp_valid[i] = out_valid && (out_id==i); rsp_id = out_id.
- Throughput: one issue per cycle. Back-to-back grants to the same requester are allowed when it is the only requester valid.
- Responses: no backpressure; requesters must accept rsp_valid pulses unconditionally.
- FSM states:
  - RUN: grants enabled. pause=1 -> DRAIN at next edge. The grant in the cycle pause rises still completes if valid.
  - DRAIN: req_ready=0. pause=0 -> RUN. If the pipe is empty and pause=1 -> HALT.
  - HALT: req_ready=0, idle=1. pause=0 -> RUN.
- idle = no tag-pipe stage valid && no transfer this cycle. idle is meaningful in every state.
- Simultaneous pause and last transfer: the transfer is accepted, DRAIN waits for its response, then HALT.

Optional Feature:
Macro IDDMM_ARB_STATS_EN.
- Defined: adds outputs stat_issue (32-bit) and stat_stall (32-bit).
  - stat_issue counts transfers.
  - stat_stall counts cycles where any req_valid=1 but no transfer occurred.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package iddmm_pkg holds:
  - IDDMM_WIDTH=256
  - IDDMM_MUL_LATENCY=8
  - arb_state_t enum {ARB_RUN, ARB_DRAIN, ARB_HALT}
  - tag_t struct {logic vld; logic [ID_W-1:0] id}
- Sub-module: iddmm_mul_256_to_512 instantiated inside, with ports clk, rst_n, x, y, result.
- The round-robin pick stays inline; no separate module.

Test Plan:
- Single request: req_valid=0001, x=3, y=5 -> req_ready=0001 one cycle. rsp_valid=0001 exactly MUL_LATENCY cycles after the operand load, rsp_data=15, rsp_id=0.
- All four valid continuously with random 256-bit operands -> grants rotate 0,1,2,3,0... Each rsp_data equals x*y of the matching requester, in issue order. 100 transactions, no gaps.
- Requesters 1 and 3 only valid -> grants alternate 1,3,1,3. Requesters 0 and 2 never see ready or rsp_valid.
- x=y=2^256-1 -> rsp_data = 2^512 - 2^257 + 1. Also x=0 -> rsp_data=0.
- pause=1 with 3 ops in flight -> req_ready=0 from the next cycle. 3 responses still delivered, then HALT with idle=1. pause=0 -> grants resume, starting from last_grant+1.
- rst_n=0 for one cycle with 5 ops in flight -> no rsp_valid afterwards, idle=1, the next grant goes to requester 0 when all are valid. With IDDMM_ARB_STATS_EN, stat_issue=0 after reset.
